// File: rtl/windower_kxt.sv
// windower_kxt: 1-D convolution windower, K-wide windows, T samples per beat.
// Holds a sliding sample history, emits one zero-padded window span per beat and
// self-flushes the tail windows of each image with zeros.
module windower_kxt #(
    parameter int NO_CH         = 2,
    parameter int LOG2_IMG_SIZE = 10,
    parameter int THROUGHPUT    = 1,
    parameter int WINDOW_SIZE   = 3
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          vld_in,
    output logic                                          rdy_in,
    input  logic [NO_CH*THROUGHPUT-1:0]                   data_in,
    output logic                                          vld_out,
    output logic                                          sof_out,
    output logic                                          eof_out,
    output logic [NO_CH*(THROUGHPUT+WINDOW_SIZE-1)-1:0]   data_out
);
    localparam int T   = THROUGHPUT;
    localparam int P   = (WINDOW_SIZE - 1) / 2;
    localparam int D   = (P + T - 1) / T;
    localparam int W   = T + 2 * P;
    localparam int N   = 1 << LOG2_IMG_SIZE;
    localparam int B   = N / T;
    localparam int LB  = (B > 1) ? $clog2(B) : 1;
    localparam int L   = (D + 1) * T + P;
    // slot of the newest sample in the window once the lookahead beat is in
    localparam int OFS = D * T - P;

    localparam logic [LB-1:0] LAST      = LB'(B - 1);
    localparam logic [LB-1:0] FILL_LAST = LB'(D - 1);

    if (WINDOW_SIZE < 3 || (WINDOW_SIZE % 2) == 0) begin : g_bad_k
        $error("windower_kxt: WINDOW_SIZE must be odd and >= 3");
    end
    if (T < 1 || (T & (T - 1)) != 0) begin : g_bad_t
        $error("windower_kxt: THROUGHPUT must be a power of 2");
    end
    if (D >= B) begin : g_bad_d
        $error("windower_kxt: lookahead beats must be fewer than beats per image");
    end

    typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

    state_t                      state;
    logic                        run;
    logic [LB-1:0]               in_cnt;
    logic [LB-1:0]               out_cnt;
    logic [L-1:0][NO_CH-1:0]     sr;
    logic [L-1:0][NO_CH-1:0]     sr_nxt;
    logic [W*NO_CH-1:0]          win;
    logic                        acc, flush, step, emit;

    // ready is pure state decode; low while flushing and until the first clock after reset
    assign rdy_in = run && (state != FLUSH);
    assign acc    = vld_in && rdy_in;
    assign flush  = (state == FLUSH);
    assign step   = acc || flush;
    assign emit   = (acc && state == STREAM) || flush;

    // history shifted by one beat: slot 0 is newest, new beat's slot T-1 is its oldest sample
    always_comb begin
        sr_nxt = sr;
        for (int k = 0; k < T; k++)
            sr_nxt[k] = flush ? '0 : data_in[k*NO_CH +: NO_CH];
        for (int k = T; k < L; k++)
            sr_nxt[k] = sr[k-T];
    end

    // window span taken from the post-shift history so it leaves on the stepping edge
    always_comb begin
        win = '0;
        for (int m = 0; m < W; m++)
            win[m*NO_CH +: NO_CH] = sr_nxt[OFS+m];
    end

    // control FSM, counters, history and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FILL;
            run      <= 1'b0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            sr       <= '0;
            vld_out  <= 1'b0;
            sof_out  <= 1'b0;
            eof_out  <= 1'b0;
            data_out <= '0;
        end else begin
            run     <= 1'b1;
            vld_out <= emit;
            sof_out <= emit && (out_cnt == '0);
            eof_out <= emit && (out_cnt == LAST);
            if (emit) begin
                data_out <= win;
                out_cnt  <= out_cnt + 1'b1;
            end
            if (acc)
                in_cnt <= in_cnt + 1'b1;
            // last flush step clears history so the next image sees zero left padding
            if (step)
                sr <= (flush && out_cnt == LAST) ? '0 : sr_nxt;
            case (state)
                FILL:    if (acc && in_cnt == FILL_LAST) state <= STREAM;
                STREAM:  if (acc && in_cnt == LAST)      state <= FLUSH;
                FLUSH:   if (out_cnt == LAST)            state <= FILL;
                default: state <= FILL;
            endcase
        end
    end
endmodule
